stream_decifrador: RTL

Receive-side stream-cipher unit: accepts a serial ciphertext bit stream and regenerates the 8-bit LFSR keystream from the shared seed. It XORs each ciphertext bit with the keystream to recover plaintext, and reassembles bytes MSB-first. Completed bytes are delivered through a one-byte valid/ready holding register. It sits at the far end of the link, after the keystream encryptor, and produces the plaintext byte stream for downstream consumers.

---
 rtl/stream_decifrador_pkg.sv | 24 ++
 rtl/stream_decifrador_if.sv | 39 +++
 rtl/stream_decifrador_lfsr8_keystream.sv | 29 ++
 rtl/stream_decifrador.sv | 118 +++++++++++
 4 files changed

// File: rtl/stream_decifrador_pkg.sv
// Shared definitions for the keystream cipher pair (encryptor and decryptor sides).
// Holds the LFSR tap set, the zero-seed substitute and the message FSM states.
package streamcipher_pkg;

    localparam logic [7:0] LFSR_TAPS     = 8'b0001_1101;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feedback is the XOR of the tapped bits; the register shifts toward bit 0.
    function automatic logic [7:0] lfsrNext(input logic [7:0] state);
        return {^(state & LFSR_TAPS), state[7:1]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [7:0] seedFix(input logic [7:0] seed);
        return (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    endfunction

endpackage

// File: rtl/stream_decifrador_if.sv
// Bundle of the key/bit input stream and the plaintext byte output handshake.
// The master side drives the stream and byte_ready; the slave side is the decryptor.
interface stream_decifrador_if;

    logic       key_load;
    logic [7:0] key;
    logic       bit_valid;
    logic       bit_in;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       overflow;
    logic       done;

    modport master (
        output key_load,
        output key,
        output bit_valid,
        output bit_in,
        output byte_ready,
        input  byte_valid,
        input  byte_out,
        input  overflow,
        input  done
    );

    modport slave (
        input  key_load,
        input  key,
        input  bit_valid,
        input  bit_in,
        input  byte_ready,
        output byte_valid,
        output byte_out,
        output overflow,
        output done
    );

endinterface

// File: rtl/stream_decifrador_lfsr8_keystream.sv
// 8-bit keystream generator: one keystream bit per step, reseeded by load.
// A zero seed is substituted internally so the register can never stall at zero.
module lfsr8_keystream
    import streamcipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic       ks_bit
);

    logic [7:0] r_lfsr;

    // Load wins over step so a reseed never consumes a keystream bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= ZERO_SEED_SUB;
        end else if (load) begin
            r_lfsr <= seedFix(seed);
        end else if (step) begin
            r_lfsr <= lfsrNext(r_lfsr);
        end
    end

    assign ks_bit = r_lfsr[0];

endmodule

// File: rtl/stream_decifrador.sv
// Receive-side stream cipher: XORs ciphertext bits with the regenerated keystream,
// assembles plaintext bytes MSB-first and offers them through a one-byte valid/ready register.
module stream_decifrador
    import streamcipher_pkg::*;
#(
    parameter int MSG_BYTES = 39
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_decifrador_if.slave  bus
);

    localparam logic [5:0] LAST_BYTE = 6'(MSG_BYTES - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_bitCnt;
    logic [5:0] r_byteCnt;
    logic [7:0] r_asm;
    logic [7:0] r_byteOut;
    logic       r_byteValid;
    logic       r_overflow;
    logic       r_done;

    logic       w_ksBit;
    logic       w_accept;
    logic       w_byteDone;
    logic       w_lastByte;
    logic [7:0] w_asmNext;

    lfsr8_keystream u_keystream (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.key_load),
        .seed   (bus.key),
        .step   (w_accept),
        .ks_bit (w_ksBit)
    );

    assign w_asmNext = {r_asm[6:0], bus.bit_in ^ w_ksBit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A bit is only taken in RUN, and never in a key_load cycle.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_byteDone  = 1'b0;
        w_lastByte  = 1'b0;
        w_accept    = (r_state == RUN) && bus.bit_valid && !bus.key_load;
        w_byteDone  = w_accept && (r_bitCnt == 3'd7);
        w_lastByte  = w_byteDone && (r_byteCnt == LAST_BYTE);
        if (bus.key_load) begin
            w_nextState = RUN;
        end else if (w_lastByte) begin
            w_nextState = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitCnt  <= 3'd0;
            r_byteCnt <= 6'd0;
            r_asm     <= 8'h00;
        end else if (bus.key_load) begin
            r_bitCnt  <= 3'd0;
            r_byteCnt <= 6'd0;
            r_asm     <= 8'h00;
        end else if (w_accept) begin
            r_bitCnt <= r_bitCnt + 3'd1;
            r_asm    <= w_asmNext;
            if (w_byteDone) begin
                r_byteCnt <= r_byteCnt + 6'd1;
            end
        end
    end

    // A completed byte only lands if the holder is empty or is being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byteValid <= 1'b0;
            r_byteOut   <= 8'h00;
            r_overflow  <= 1'b0;
        end else if (bus.key_load) begin
            r_byteValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_byteDone) begin
            if (!r_byteValid || bus.byte_ready) begin
                r_byteOut   <= w_asmNext;
                r_byteValid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (bus.byte_ready) begin
            r_byteValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_lastByte;
        end
    end

    assign bus.byte_valid = r_byteValid;
    assign bus.byte_out   = r_byteOut;
    assign bus.overflow   = r_overflow;
    assign bus.done       = r_done;

endmodule
